// File: rtl/bcd_sched_pkg.sv
// Shared types for the bin2bcd converter scheduler: FSM states and the
// packed 4-digit BCD result.
package bcd_sched_pkg;

    localparam int DIGITS = 4;

    typedef logic [4*DIGITS-1:0] bcd4_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/bcd_conv_sched_arb.sv
// Combinational round-robin arbiter: grants the first requester found
// searching upward from i_ptr+1 with wrap.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic [NREQ-1:0]         o_grant,
    output logic [$clog2(NREQ)-1:0] o_idx
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] w_cand;
    logic          w_found;

    // NOTE: every combinational output gets a default before the search so
    // no path leaves a variable unassigned, which would infer a latch.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IW'((int'(i_ptr) + k) % NREQ);
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one bin2bcd converter among NREQ requesters,
// with a watchdog that aborts conversions whose done never arrives.
module bcd_conv_sched
    import bcd_sched_pkg::*;
#(
    parameter int N       = 7,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_bin,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   resp_valid,
    output bcd4_t             resp_bcd,
    output logic              resp_err,
    output logic              cv_start,
    output logic [N-1:0]      cv_bin,
    input  logic              cv_done,
    input  bcd4_t             cv_bcd,
    output logic              busy
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT) + 1;

    if (N < 1 || N > 13) begin : g_bad_n
        $error("bcd_conv_sched: N must be 1..13");
    end
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("bcd_conv_sched: NREQ must be 2..8");
    end
    if (TIMEOUT < N + 4) begin : g_bad_timeout
        $error("bcd_conv_sched: TIMEOUT must be at least N+4");
    end

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_gidx;
    logic [IW-1:0]   w_gidx;
    logic [NREQ-1:0] w_grant;
    logic [TW-1:0]   r_timer;
    logic            w_take_done;
    logic            w_timeout;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx)
    );

    // A level done left over from the previous conversion is still visible
    // in the first WAIT cycle, so it is only trusted from timer==1 onward.
    assign w_take_done = (r_state == WAIT) && cv_done && (r_timer != '0);
    assign w_timeout   = (r_state == WAIT) && (r_timer == TW'(TIMEOUT - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ptr    <= IW'(NREQ - 1);
            r_gidx   <= '0;
            r_timer  <= '0;
            cv_bin   <= '0;
            resp_bcd <= '0;
            resp_err <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (|req_valid) begin
                        cv_bin <= req_bin[int'(w_gidx)*N +: N];
                        r_gidx <= w_gidx;
                    end
                end
                START: r_timer <= '0;
                WAIT: begin
                    r_timer <= r_timer + TW'(1);
                    if (w_take_done) begin
                        resp_bcd <= cv_bcd;
                        resp_err <= 1'b0;
                    end else if (w_timeout) begin
                        resp_bcd <= '0;
                        resp_err <= 1'b1;
                    end
                end
                RESP: r_ptr <= r_gidx;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = '0;
        resp_valid = '0;
        cv_start   = 1'b0;
        busy       = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (!rst && |req_valid) begin
                    req_ready = w_grant;
                    w_next    = START;
                end
            end
            START: begin
                cv_start = 1'b1;
                w_next   = WAIT;
            end
            WAIT: begin
                if (w_take_done || w_timeout) w_next = RESP;
            end
            RESP: begin
                resp_valid[r_gidx] = 1'b1;
                w_next             = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Self-checking bench: converter model, directed vector table, multi-request
// sequences, reset abort and randomized traffic against a scheduling model.
module tb_bcd_conv_sched;
    import bcd_sched_pkg::*;

    localparam int N       = 7;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_bin;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   resp_valid;
    bcd4_t             resp_bcd;
    logic              resp_err;
    logic              cv_start;
    logic [N-1:0]      cv_bin;
    logic              cv_done;
    bcd4_t             cv_bcd;
    logic              busy;

    bcd_conv_sched #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_bin    (req_bin),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_bcd   (resp_bcd),
        .resp_err   (resp_err),
        .cv_start   (cv_start),
        .cv_bin     (cv_bin),
        .cv_done    (cv_done),
        .cv_bcd     (cv_bcd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic bcd4_t bcd_of(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (last + k) % NREQ;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Converter model: done after cv_lat cycles; in level mode done stays high
    // until one cycle after the next start, as a registered converter would.
    int           cv_lat   = 1;
    bit           cv_level = 1'b0;
    bit           cv_never = 1'b0;
    logic [N-1:0] cm_op;
    int           cm_cnt;
    logic         cm_start_d;

    always @(posedge clk) begin
        if (rst) begin
            cv_done    <= 1'b0;
            cv_bcd     <= '0;
            cm_cnt     <= 0;
            cm_start_d <= 1'b0;
            cm_op      <= '0;
        end else begin
            cm_start_d <= cv_start;
            if (!cv_level) cv_done <= 1'b0;
            if (cm_start_d) cv_done <= 1'b0;
            if (cv_start) begin
                cm_op  <= cv_bin;
                cm_cnt <= cv_lat;
            end else if (cm_cnt > 0) begin
                cm_cnt <= cm_cnt - 1;
                if (cm_cnt == 1 && !cv_never) begin
                    cv_done <= 1'b1;
                    cv_bcd  <= bcd_of(int'(cm_op));
                end
            end
        end
    end

    // Scheduling model: the requester last answered has lowest priority.
    typedef struct {
        int    g;
        bcd4_t bcd;
        bit    err;
    } exp_t;

    exp_t            exp_q[$];
    int              grant_log[$];
    bcd4_t           resp_log[$];
    int              last_served;
    int              acc_g;
    int              cyc;
    int              start_cyc;
    int              last_lat;
    bcd4_t           last_bcd;
    logic            last_err;
    logic [NREQ-1:0] inj_v;
    int              inj_bin[NREQ];

    task automatic model_reset();
        exp_q.delete();
        last_served = NREQ - 1;
        acc_g       = -1;
    endtask

    task automatic serve(input int budget, input bit rand_new);
        int   n;
        bit   fin;
        int   cleared;
        int   g;
        exp_t e;
        n   = 0;
        fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            cleared = acc_g;
            if (acc_g >= 0) begin
                req_valid[acc_g] = 1'b0;
                acc_g = -1;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (inj_v[i]) begin
                    req_valid[i]      = 1'b1;
                    req_bin[i*N +: N] = N'(inj_bin[i]);
                end
            end
            inj_v = '0;
            if (rand_new) begin
                cv_lat = $urandom_range(1, 12);
                for (int i = 0; i < NREQ; i++) begin
                    if (!req_valid[i] && i != cleared && $urandom_range(0, 3) == 0) begin
                        req_valid[i]      = 1'b1;
                        req_bin[i*N +: N] = N'($urandom_range(0, 127));
                    end else if (req_valid[i] && $urandom_range(0, 31) == 0) begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            #1;
            cyc++;
            n++;
            if (cv_start) start_cyc = cyc;
            if (req_ready != '0) begin
                g = pick(req_valid, last_served);
                if (g < 0) begin
                    check("grant_without_valid", 32'(req_ready), 32'd0);
                end else begin
                    check("grant", 32'(req_ready), 32'd1 << g);
                    e.g   = g;
                    e.err = cv_never;
                    e.bcd = cv_never ? '0 : bcd_of(int'(req_bin[g*N +: N]));
                    exp_q.push_back(e);
                    grant_log.push_back(g);
                    acc_g = g;
                end
            end
            if (resp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    check("spurious_resp", 32'(resp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_onehot", 32'(resp_valid), 32'd1 << e.g);
                    check("resp_bcd", 32'(resp_bcd), 32'(e.bcd));
                    check("resp_err", 32'(resp_err), 32'(e.err));
                    last_served = e.g;
                    last_lat    = cyc - start_cyc;
                    last_bcd    = resp_bcd;
                    last_err    = resp_err;
                    resp_log.push_back(resp_bcd);
                end
            end
            if (rand_new) begin
                fin = (n >= budget);
            end else if (req_valid == '0 && exp_q.size() == 0 && acc_g < 0) begin
                fin = 1'b1;
            end else if (n >= budget) begin
                n_cmp++;
                n_bad++;
                $display("FAIL serve_budget: %0d cycles without draining, %0d responses outstanding",
                         n, exp_q.size());
                fin = 1'b1;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_cv_start"}, 32'(cv_start), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_resp_bcd"}, 32'(resp_bcd), 32'd0);
        check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        check({tag, "_cv_bin"}, 32'(cv_bin), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        int    r;
        int    bin;
        int    lat;
        bit    level;
        bit    never;
        bcd4_t exp_bcd;
        bit    exp_err;
        int    exp_lat;
    } vec_t;

    vec_t            vecs[7];
    logic [NREQ-1:0] seen;

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_bin   = '0;
        inj_v     = '0;
        cyc       = 0;
        start_cyc = 0;
        last_lat  = 0;
        model_reset();

        // Latency is start-to-response: converter latency + 2, or 65 on timeout.
        vecs[0] = '{r: 0, bin: 7,   lat: 9, level: 0, never: 0, exp_bcd: 16'h0007, exp_err: 0, exp_lat: 11};
        vecs[1] = '{r: 2, bin: 127, lat: 3, level: 0, never: 0, exp_bcd: 16'h0127, exp_err: 0, exp_lat: 5};
        vecs[2] = '{r: 3, bin: 99,  lat: 1, level: 1, never: 0, exp_bcd: 16'h0099, exp_err: 0, exp_lat: 3};
        vecs[3] = '{r: 1, bin: 120, lat: 4, level: 1, never: 0, exp_bcd: 16'h0120, exp_err: 0, exp_lat: 6};
        vecs[4] = '{r: 0, bin: 0,   lat: 2, level: 1, never: 0, exp_bcd: 16'h0000, exp_err: 0, exp_lat: 4};
        vecs[5] = '{r: 2, bin: 64,  lat: 1, level: 0, never: 1, exp_bcd: 16'h0000, exp_err: 1, exp_lat: 65};
        vecs[6] = '{r: 1, bin: 85,  lat: 6, level: 0, never: 0, exp_bcd: 16'h0085, exp_err: 0, exp_lat: 8};

        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // All four requesters at once: strictly cyclic from requester 0.
        grant_log.delete();
        resp_log.delete();
        inj_v   = 4'b1111;
        inj_bin = '{53, 99, 120, 0};
        serve(400, 1'b0);
        check("t2_n_grants", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size()) check($sformatf("t2_grant%0d", i), 32'(grant_log[i]), 32'(i));
        end
        if (resp_log.size() == 4) begin
            check("t2_resp0", 32'(resp_log[0]), 32'h0053);
            check("t2_resp1", 32'(resp_log[1]), 32'h0099);
            check("t2_resp2", 32'(resp_log[2]), 32'h0120);
            check("t2_resp3", 32'(resp_log[3]), 32'h0000);
        end

        // Serve requester 1, then 0 and 1 together: 0 wins by wrap.
        grant_log.delete();
        inj_v      = 4'b0010;
        inj_bin[1] = 42;
        serve(100, 1'b0);
        inj_v      = 4'b0011;
        inj_bin[0] = 11;
        inj_bin[1] = 77;
        serve(200, 1'b0);
        check("t3_n_grants", 32'(grant_log.size()), 32'd3);
        if (grant_log.size() == 3) begin
            check("t3_first", 32'(grant_log[1]), 32'd0);
            check("t3_second", 32'(grant_log[2]), 32'd1);
        end

        pulse_reset();
        foreach (vecs[i]) begin
            cv_lat            = vecs[i].lat;
            cv_level          = vecs[i].level;
            cv_never          = vecs[i].never;
            inj_v             = '0;
            inj_v[vecs[i].r]  = 1'b1;
            inj_bin[vecs[i].r] = vecs[i].bin;
            serve(300, 1'b0);
            check($sformatf("vec%0d_latency", i), 32'(last_lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_bcd", i), 32'(last_bcd), 32'(vecs[i].exp_bcd));
            check($sformatf("vec%0d_err", i), 32'(last_err), 32'(vecs[i].exp_err));
            @(negedge clk);
            #1;
            check($sformatf("vec%0d_idle", i), 32'(busy), 32'd0);
        end

        // Reset during WAIT: silent abort, pointer back to requester 0 first.
        @(negedge clk);
        cv_never     = 1'b1;
        cv_level     = 1'b0;
        req_valid[2] = 1'b1;
        req_bin[2*N +: N] = 7'd33;
        #1;
        check("t6_accept", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid[2] = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("t6_busy_in_wait", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_reset_outputs("t6_reset");
        rst = 1'b0;
        model_reset();
        seen = '0;
        repeat (80) begin
            @(negedge clk);
            #1;
            seen |= resp_valid;
        end
        check("t6_no_resp", 32'(seen), 32'd0);
        cv_never   = 1'b0;
        cv_lat     = 2;
        grant_log.delete();
        inj_v      = 4'b1001;
        inj_bin[0] = 5;
        inj_bin[3] = 6;
        serve(200, 1'b0);
        if (grant_log.size() > 0) check("t6_first_after_reset", 32'(grant_log[0]), 32'd0);
        else check("t6_n_grants", 32'(grant_log.size()), 32'd2);

        // Randomized traffic, pulse then level done, then drain.
        cv_level = 1'b0;
        serve(1500, 1'b1);
        cv_level = 1'b1;
        serve(1500, 1'b1);
        serve(2000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
